// File: rtl/proc_io_ctrl.sv
// Run sequencer and I/O scheduler for the SSF-GDP core.
// Buffers ADC samples, sequences core reset, feeds requests, forwards results.
module proc_io_ctrl #(
    parameter int DW_IN      = 12,
    parameter int DW_OUT     = 21,
    parameter int FIFO_DEPTH = 16,
    parameter int RST_CYC    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       n_samples,
    input  logic [15:0]       n_outputs,
    input  logic [DW_IN-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DW_IN-1:0]  proc_in,
    output logic              proc_rst,
    input  logic [3:0]        proc_req,
    input  logic [DW_OUT-1:0] proc_out,
    input  logic [3:0]        proc_oen,
    output logic [DW_OUT-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              err_underrun,
    output logic              err_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRELOAD, S_RESET, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DW_IN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             empty, push, pop;

    logic [CW-1:0] rst_cnt;
    logic [15:0]   n_s, n_o, in_cnt, out_cnt;
    logic          accept, under, all_done;
    logic          cap_en, cap, ovf, run_ph;

    assign empty   = (count == '0);
    assign s_ready = (count != FULL_CNT);
    assign push    = s_valid && s_ready && !abort;

    assign run_ph   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign proc_rst = !run_ph;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);

    assign all_done = (in_cnt == n_s) && (out_cnt == n_o) && !m_valid;

    // A word arriving while the sink stalls a held word is lost.
    assign cap_en = run_ph && (proc_oen == 4'd1) && (out_cnt < n_o) && !abort;
    assign cap    = cap_en && (!m_valid || m_ready);
    assign ovf    = cap_en && !cap;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        under   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && n_samples != '0) begin
                    accept  = 1'b1;
                    state_d = S_PRELOAD;
                end
            end
            S_PRELOAD: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_RESET;
                end
            end
            S_RESET: begin
                if (rst_cnt == RST_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (all_done) begin
                    state_d = S_DONE;
                end else if (in_cnt == n_s) begin
                    state_d = S_DRAIN;
                end else if (proc_req == 4'd1) begin
                    if (empty) under = 1'b1;
                    else       pop   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (all_done) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            pop     = 1'b0;
            under   = 1'b0;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rst_cnt      <= '0;
            n_s          <= '0;
            n_o          <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            proc_in      <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            err_underrun <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            rst_cnt <= (state_q == S_RESET) ? rst_cnt + 1'b1 : '0;
            if (accept) begin
                n_s          <= n_samples;
                n_o          <= n_outputs;
                in_cnt       <= '0;
                out_cnt      <= '0;
                err_underrun <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (pop) begin
                proc_in <= mem[rd_ptr];
                in_cnt  <= in_cnt + 16'd1;
            end
            if (under) err_underrun <= 1'b1;
            if (ovf)   err_overflow <= 1'b1;
            if (abort) begin
                m_valid <= 1'b0;
            end else if (cap) begin
                m_valid <= 1'b1;
                m_data  <= proc_out;
                out_cnt <= out_cnt + 16'd1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_proc_io_ctrl.sv
// Directed bench for proc_io_ctrl: nominal, underrun, overflow,
// backpressure, abort and asynchronous reset scenarios.
module tb_proc_io_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] n_samples = '0;
    logic [15:0] n_outputs = '0;
    logic [11:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] proc_in;
    logic        proc_rst;
    logic [3:0]  proc_req = '0;
    logic [20:0] proc_out = '0;
    logic [3:0]  proc_oen = '0;
    logic [20:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        err_underrun;
    logic        err_overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int dcnt;

    proc_io_ctrl #(
        .DW_IN(12), .DW_OUT(21), .FIFO_DEPTH(16), .RST_CYC(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_samples(n_samples), .n_outputs(n_outputs),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .proc_in(proc_in), .proc_rst(proc_rst), .proc_req(proc_req),
        .proc_out(proc_out), .proc_oen(proc_oen),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done),
        .err_underrun(err_underrun), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [11:0] d);
        s_data  = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic go(input logic [15:0] ns, input logic [15:0] no);
        n_samples = ns;
        n_outputs = no;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic req();
        proc_req = 4'd1;
        tick();
        proc_req = 4'd0;
    endtask

    task automatic res(input logic [20:0] v);
        proc_out = v;
        proc_oen = 4'd1;
        tick();
        proc_oen = 4'd0;
    endtask

    task automatic watch_done(input int cyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < cyc; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    initial begin
        #12;
        chk("rst_proc_in", 32'(proc_in), 0);
        chk("rst_proc_rst", 32'(proc_rst), 1);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_errs", 32'({err_underrun, err_overflow}), 0);
        rst = 1'b1;
        tick();

        // nominal: 8 samples, 2 results
        for (int i = 0; i < 8; i++) push(12'(12'h8F0 + i * 17));
        go(16'd8, 16'd2);
        chk("nom_busy", 32'(busy), 1);
        tick();
        chk("nom_preload", 32'(proc_in), 32'(12'h8F0));
        ticks(4);
        chk("nom_rst_hold", 32'(proc_rst), 1);
        tick();
        chk("nom_rst_rel", 32'(proc_rst), 0);
        for (int i = 1; i < 8; i++) begin
            ticks(2);
            req();
            chk("nom_proc_in", 32'(proc_in), 32'(12'(12'h8F0 + i * 17)));
        end
        res(21'h1ABCD);
        chk("nom_m_data_a", 32'(m_data), 32'h1ABCD);
        chk("nom_m_valid", 32'(m_valid), 1);
        res(21'h0F00F);
        chk("nom_m_data_b", 32'(m_data), 32'h0F00F);
        watch_done(8, dcnt);
        chk("nom_done_cnt", 32'(dcnt), 1);
        chk("nom_errs", 32'({err_underrun, err_overflow}), 0);
        chk("nom_idle", 32'(busy), 0);

        // underrun
        push(12'h0C1);
        push(12'h0C2);
        go(16'd4, 16'd1);
        ticks(6);
        chk("und_run", 32'(proc_rst), 0);
        req();
        chk("und_in2", 32'(proc_in), 32'h0C2);
        req();
        chk("und_flag", 32'(err_underrun), 1);
        chk("und_hold", 32'(proc_in), 32'h0C2);
        push(12'h0C3);
        push(12'h0C4);
        req();
        chk("und_in3", 32'(proc_in), 32'h0C3);
        req();
        chk("und_in4", 32'(proc_in), 32'h0C4);
        res(21'h00777);
        watch_done(8, dcnt);
        chk("und_done_cnt", 32'(dcnt), 1);
        chk("und_sticky", 32'(err_underrun), 1);

        // overflow
        m_ready = 1'b0;
        push(12'h0D1);
        go(16'd1, 16'd2);
        chk("ovf_clr_und", 32'(err_underrun), 0);
        ticks(6);
        res(21'h11111);
        ticks(3);
        res(21'h02222);
        chk("ovf_hold", 32'(m_data), 32'h11111);
        chk("ovf_valid", 32'(m_valid), 1);
        chk("ovf_flag", 32'(err_overflow), 1);
        chk("ovf_no_done", 32'(busy), 1);
        m_ready = 1'b1;
        res(21'h03333);
        chk("ovf_w3", 32'(m_data), 32'h03333);
        watch_done(8, dcnt);
        chk("ovf_done_cnt", 32'(dcnt), 1);

        // backpressure, then abort mid-run
        for (int i = 0; i < 16; i++) begin
            s_data  = 12'(12'h200 + i);
            s_valid = 1'b1;
            tick();
            if (i == 14) chk("bp_ready15", 32'(s_ready), 1);
        end
        chk("bp_full", 32'(s_ready), 0);
        s_data = 12'h2FF;
        go(16'd4, 16'd1);
        chk("bp_still_full", 32'(s_ready), 0);
        tick();
        chk("bp_pop_rise", 32'(s_ready), 1);
        chk("bp_order", 32'(proc_in), 32'h200);
        tick();
        chk("bp_refull", 32'(s_ready), 0);
        s_valid = 1'b0;
        ticks(4);
        req();
        chk("ab_in1", 32'(proc_in), 32'h201);
        req();
        chk("ab_in2", 32'(proc_in), 32'h202);
        m_ready = 1'b0;
        res(21'h0AAAA);
        chk("ab_mv_pre", 32'(m_valid), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle", 32'(busy), 0);
        chk("ab_proc_rst", 32'(proc_rst), 1);
        chk("ab_m_valid", 32'(m_valid), 0);
        chk("ab_s_ready", 32'(s_ready), 1);
        watch_done(3, dcnt);
        chk("ab_no_done", 32'(dcnt), 0);
        go(16'd1, 16'd0);
        ticks(2);
        chk("ab_empty_wait", 32'(busy), 1);
        chk("ab_empty_in", 32'(proc_in), 32'h202);
        push(12'h0E5);
        tick();
        chk("ab_new_pop", 32'(proc_in), 32'h0E5);
        watch_done(12, dcnt);
        chk("ab_done_cnt", 32'(dcnt), 1);

        // async reset in DRAIN
        push(12'h0F1);
        go(16'd1, 16'd1);
        ticks(7);
        res(21'h12345);
        chk("dr_busy", 32'(busy), 1);
        chk("dr_m_valid", 32'(m_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_proc_in", 32'(proc_in), 0);
        chk("ar_proc_rst", 32'(proc_rst), 1);
        chk("ar_m_valid", 32'(m_valid), 0);
        chk("ar_m_data", 32'(m_data), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_s_ready", 32'(s_ready), 1);
        rst = 1'b1;
        m_ready = 1'b1;
        go(16'd0, 16'd1);
        chk("ar_zero_start", 32'(busy), 0);
        tick();
        chk("ar_zero_start2", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/proc_io_ctrl.md
# proc_io_ctrl

Run sequencer and I/O scheduler for the SSF-GDP processor core. It buffers incoming 12-bit ADC samples in a FIFO and holds the core in reset while idle. On command it preloads the first sample, releases the core, serves each sample request, and forwards each result word to a downstream valid/ready sink. It sits between the sample source and sink and the core's `in`/`req_in`/`io_out`/`out_en` ports, replacing the file-driven stimulus used in simulation.

## Interface
- `DW_IN`, 12, sample width (signed)
- `DW_OUT`, 21, result width
- `FIFO_DEPTH`, 16, input FIFO depth, power of 2, ≥2
- `RST_CYC`, 5, cycles the core reset is held after preload (≥1)

Ports:
- `clk  input  1  single clock, all logic on rising edge`
- `rst  input  1  asynchronous, active-low reset`
- `start  input  1  begin a run (pulse)`
- `abort  input  1  cancel run (pulse)`
- `n_samples  input  16  samples to feed; latched on accepted start`
- `n_outputs  input  16  results expected; latched on accepted start`
- `s_data  input  DW_IN  sample in`
- `s_valid  input  1  sample valid`
- `s_ready  output  1  = FIFO not full`
- `proc_in  output  DW_IN  to core `in``
- `proc_rst  output  1  to core `rst`, active-high`
- `proc_req  input  4  core `req_in`; value 4'd1 = request`
- `proc_out  input  DW_OUT  core `io_out``
- `proc_oen  input  4  core `out_en`; value 4'd1 = result valid`
- `m_data  output  DW_OUT  result out`
- `m_valid  output  1  result valid`
- `m_ready  input  1  sink ready`
- `busy  output  1  state not IDLE/DONE`
- `done  output  1  one-cycle pulse at run end`
- `err_underrun  output  1  sticky`
- `err_overflow  output  1  sticky`

## Operation
- FIFO write on `s_valid && s_ready` in any state except in the abort cycle. The FIFO is flushed on reset and on abort.
- Other `proc_req`/`proc_oen` values are ignored.
- States:
  - IDLE: start with `n_samples != 0` → PRELOAD. Latch the counts, clear the error flags and in/out counters. Start with `n_samples == 0` is ignored.
  - PRELOAD: when FIFO not empty, pop into `proc_in`, `in_cnt = 1`, → RESET.
  - RESET: hold for `RST_CYC` cycles, then → RUN.
  - RUN: on `proc_req == 4'd1`:
    - If `in_cnt < n_samples` and FIFO not empty: pop into `proc_in`, `in_cnt++`.
    - If `in_cnt < n_samples` and FIFO empty: set `err_underrun`; `proc_in` holds and `in_cnt` is unchanged.
    - When `in_cnt == n_samples`: → DRAIN. Later requests are ignored with no underrun.
  - DRAIN: wait. When `in_cnt == n_samples && out_cnt == n_outputs && !m_valid` (evaluated in RUN or DRAIN) → DONE.
  - DONE: `done = 1` for one cycle, → IDLE.
- `proc_rst` = 1 in IDLE, PRELOAD, RESET, DONE; 0 in RUN, DRAIN.
- Output capture (RUN/DRAIN only) on `proc_oen == 4'd1` with `out_cnt < n_outputs`:
  - If `!m_valid || m_ready`: `m_data <= proc_out`, `m_valid <= 1`, `out_cnt++`.
  - Otherwise drop the word, set `err_overflow`, and leave `out_cnt` unchanged.
  - Words arriving with `out_cnt == n_outputs` are ignored.
- `m_valid` clears on `m_ready` unless a capture happens in the same cycle.
- `abort` (any state) → IDLE next edge, `proc_rst = 1`, `m_valid = 0`. The error flags are kept. `abort` beats `start` when both are asserted.
- `start` while busy is ignored.

## Timing
- Reset values: `proc_in = 0`, `proc_rst = 1`, `s_ready = 1`, `m_valid = 0`, `m_data = 0`, `busy = 0`, `done = 0`, both errors 0. State = IDLE.
- Start accepted at edge k → PRELOAD after k. With the FIFO already non-empty, the pop is at k+1, so `proc_in` is valid after k+1. `proc_rst` falls after edge k+1+`RST_CYC`.
- Request at edge t → new `proc_in` visible after t (1-cycle latency), matching the core's post-edge sample update.
- Result at edge t → `m_valid`/`m_data` after t.
- Simultaneous FIFO push and pop: both occur, and the count is unchanged. When full, a pop in the same cycle does not raise `s_ready` until the next cycle (registered full).
- Counters are 16-bit and never wrap; the limit is `n_samples`/`n_outputs ≤ 65535`.

## Test plan
- Nominal run: preload 8 samples, `n_samples = 8`, `n_outputs = 2`, `RST_CYC = 5`. Core model requests every 3 cycles and emits 2 results, `m_ready = 1`. Required: `proc_in` follows the FIFO order, `proc_rst` is low after start+6, `done` pulses once, no errors.
- Underrun: FIFO holds 2 samples, `n_samples = 4`, request 3rd. Required: `err_underrun = 1`, `proc_in` holds the 2nd sample. Then push 2 samples: requests 4 and 5 consume them and the run completes.
- Overflow: `m_ready = 0`, two results 4 cycles apart. Required: first word held on `m_data`, `err_overflow = 1`, `out_cnt = 1`. Raise `m_ready` and emit a 3rd result: `done` pulses after acceptance.
- Backpressure: `s_valid` constant while the core is idle. Required: `s_ready` drops after 16 writes and rises the cycle after the first pop.
- Abort mid-RUN after 3 samples. Required: next cycle IDLE, `proc_rst = 1`, FIFO empty, `m_valid = 0`, `done` never pulses.
- Reset asserted mid-DRAIN. Required: all outputs at reset values immediately (asynchronous), and `start` with `n_samples = 0` afterwards is ignored (`busy` stays 0).
